sram_port_arbiter: RTL and testbench

Shares the single-port instruction/data SRAM between the DLX fetch stage (read-only port "i") and the memory stage (read/write port "d"). Each access is sequenced through an IDLE/ACCESS/RESP state machine with a configurable number of wait states. The data port has priority; a starvation counter guarantees forward progress for fetch. The block sits between the pipeline and the `sram` instance and drives cs/oe/we/addr/din.

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_arb_pick.sv | 39 +++
 rtl/sram_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and constants for the SRAM port arbiter
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam int STARVE_W = 4;

  // Data port wins unless fetch has already lost max_wait arbitrations in a row.
  function automatic logic d_wins(input logic                d_req,
                                  input logic [STARVE_W-1:0] starve_cnt,
                                  input logic [STARVE_W-1:0] max_wait);
    return d_req && (starve_cnt < max_wait);
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - winner select between fetch and data ports plus starvation counter
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_arb,
  input  logic i_fetch_req,
  input  logic i_data_req,
  output logic o_owner,
  output logic o_any_req
);

  localparam logic [STARVE_W-1:0] MAX_W = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic                w_d_wins;

  assign w_d_wins  = d_wins(i_data_req, r_starve_cnt, MAX_W);
  assign o_owner   = w_d_wins ? OWN_D : OWN_I;
  assign o_any_req = i_data_req | i_fetch_req;

  // Only arbitration cycles with a pending fetch move the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_arb && i_fetch_req) begin
      if (w_d_wins) begin
        if (r_starve_cnt != '1)
          r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
      end else begin
        r_starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM between fetch (read-only) and data (read/write) ports
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int MAX_WAIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        sram_cs,
  output logic        sram_oe,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  input  logic [31:0] sram_dout,
  output logic        owner_d
);

  localparam int             WCW     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [WCW-1:0] WS_LOAD = WCW'(WAIT_STATES);

  state_t         r_state;
  state_t         w_next;
  logic [WCW-1:0] r_wait_cnt;
  logic [31:0]    r_addr;
  logic [31:0]    r_wdata;
  logic [31:0]    r_i_rdata;
  logic [31:0]    r_d_rdata;
  logic           r_we;
  logic           r_owner;
  logic           w_owner;
  logic           w_any_req;
  logic           w_arb;
  logic           w_last;

  assign w_arb  = (r_state == ST_IDLE);
  assign w_last = (r_wait_cnt == '0);

  sram_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk         (clk),
    .rst         (rst),
    .i_arb       (w_arb),
    .i_fetch_req (i_req),
    .i_data_req  (d_req),
    .o_owner     (w_owner),
    .o_any_req   (w_any_req)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_next = ST_ACCESS;
      ST_ACCESS: if (w_last) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sram_cs = 1'b0;
    sram_we = 1'b0;
    sram_oe = 1'b0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    case (r_state)
      ST_ACCESS: begin
        sram_cs = 1'b1;
        sram_we = r_we;
        sram_oe = ~r_we;
      end
      ST_RESP: begin
        i_ack = (r_owner == OWN_I);
        d_ack = (r_owner == OWN_D);
      end
      default: ;
    endcase
  end

  // Request fields are latched at grant so the SRAM sees a stable cycle even if req drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWN_I;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_wait_cnt <= '0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner    <= w_owner;
            r_addr     <= (w_owner == OWN_D) ? d_addr : i_addr;
            r_we       <= (w_owner == OWN_D) & d_we;
            r_wdata    <= (w_owner == OWN_D) ? d_wdata : 32'h0;
            r_wait_cnt <= WS_LOAD;
          end
        end
        ST_ACCESS: begin
          if (w_last) begin
            if (r_owner == OWN_D)
              r_d_rdata <= sram_dout;
            else
              r_i_rdata <= sram_dout;
          end else begin
            r_wait_cnt <= r_wait_cnt - WCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign owner_d   = r_owner;
  assign sram_addr = r_addr;
  assign sram_din  = r_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic clk;
  logic rst;
  logic preload;

  logic        a_i_req, a_d_req, a_d_we;
  logic [31:0] a_i_addr, a_d_addr, a_d_wdata;
  logic        a_i_ack, a_d_ack, a_cs, a_oe, a_we, a_owner_d;
  logic [31:0] a_i_rdata, a_d_rdata, a_addr, a_din, a_dout;

  logic        b_i_req, b_d_req, b_d_we;
  logic [31:0] b_i_addr, b_d_addr, b_d_wdata;
  logic        b_i_ack, b_d_ack, b_cs, b_oe, b_we, b_owner_d;
  logic [31:0] b_i_rdata, b_d_rdata, b_addr, b_din, b_dout;

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] img(input int k);
    return (k * 32'h0100_0193) ^ 32'h2545_F491;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  sram_port_arbiter #(.WAIT_STATES(0), .MAX_WAIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_ack(a_i_ack), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .sram_cs(a_cs), .sram_oe(a_oe), .sram_we(a_we), .sram_addr(a_addr),
    .sram_din(a_din), .sram_dout(a_dout), .owner_d(a_owner_d)
  );

  sram_port_arbiter #(.WAIT_STATES(2), .MAX_WAIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .sram_cs(b_cs), .sram_oe(b_oe), .sram_we(b_we), .sram_addr(b_addr),
    .sram_din(b_din), .sram_dout(b_dout), .owner_d(b_owner_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) begin
        mem_a[k] <= img(k);
        mem_b[k] <= img(k);
      end
    end else begin
      if (a_cs && a_we) mem_a[a_addr[9:2]] <= a_din;
      if (b_cs && b_we) mem_b[b_addr[9:2]] <= b_din;
    end
  end

  assign a_dout = mem_a[a_addr[9:2]];
  assign b_dout = mem_b[b_addr[9:2]];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; preload = 1'b1;
    a_i_req = 0; a_d_req = 0; a_d_we = 0; a_i_addr = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_d_req = 0; b_d_we = 0; b_i_addr = 0; b_d_addr = 0; b_d_wdata = 0;
    repeat (3) @(negedge clk);

    chk("rst_a_cs", a_cs, 0);
    chk("rst_a_oe", a_oe, 0);
    chk("rst_a_we", a_we, 0);
    chk("rst_a_iack", a_i_ack, 0);
    chk("rst_a_dack", a_d_ack, 0);
    chk("rst_a_addr", a_addr, 0);
    chk("rst_a_din", a_din, 0);
    chk("rst_a_owner", a_owner_d, 0);
    chk("rst_a_irdata", a_i_rdata, 0);
    chk("rst_a_drdata", a_d_rdata, 0);
    chk("rst_b_cs", b_cs, 0);
    chk("rst_b_owner", b_owner_d, 0);
    rst = 1'b0; preload = 1'b0;
    @(negedge clk);

    // Test 1: single fetch, zero wait states
    a_i_req = 1; a_i_addr = 32'h04;
    @(negedge clk);
    chk("t1_cs_access", a_cs, 1);
    chk("t1_oe_access", a_oe, 1);
    chk("t1_we_access", a_we, 0);
    chk("t1_addr", a_addr, 32'h04);
    chk("t1_iack_early", a_i_ack, 0);
    @(negedge clk);
    chk("t1_iack", a_i_ack, 1);
    chk("t1_irdata", a_i_rdata, img(1));
    chk("t1_dack", a_d_ack, 0);
    chk("t1_cs_resp", a_cs, 0);
    a_i_req = 0;
    @(negedge clk);
    chk("t1_iack_pulse", a_i_ack, 0);
    chk("t1_cs_idle", a_cs, 0);

    // Test 2: data write then read back
    a_d_req = 1; a_d_we = 1; a_d_addr = 32'h100; a_d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_w_cs", a_cs, 1);
    chk("t2_w_we", a_we, 1);
    chk("t2_w_oe", a_oe, 0);
    chk("t2_w_din", a_din, 32'hDEADBEEF);
    chk("t2_w_addr", a_addr, 32'h100);
    @(negedge clk);
    chk("t2_w_dack", a_d_ack, 1);
    chk("t2_w_we_resp", a_we, 0);
    a_d_req = 0;
    @(negedge clk);
    chk("t2_mem", mem_a[64], 32'hDEADBEEF);
    a_d_req = 1; a_d_we = 0; a_d_wdata = 0;
    @(negedge clk);
    chk("t2_r_we", a_we, 0);
    chk("t2_r_oe", a_oe, 1);
    @(negedge clk);
    chk("t2_r_dack", a_d_ack, 1);
    chk("t2_r_drdata", a_d_rdata, 32'hDEADBEEF);
    a_d_req = 0;
    @(negedge clk);

    // Test 3: simultaneous requests, data wins first
    a_d_req = 1; a_d_addr = 32'h100; a_i_req = 1; a_i_addr = 32'h08;
    @(negedge clk);
    chk("t3_owner_d", a_owner_d, 1);
    chk("t3_addr_d", a_addr, 32'h100);
    @(negedge clk);
    chk("t3_dack", a_d_ack, 1);
    chk("t3_iack_lose", a_i_ack, 0);
    a_d_req = 0;
    @(negedge clk);
    chk("t3_idle_cs", a_cs, 0);
    @(negedge clk);
    chk("t3_owner_i", a_owner_d, 0);
    chk("t3_addr_i", a_addr, 32'h08);
    chk("t3_i_we", a_we, 0);
    @(negedge clk);
    chk("t3_iack", a_i_ack, 1);
    chk("t3_dack_off", a_d_ack, 0);
    chk("t3_irdata", a_i_rdata, img(2));
    a_i_req = 0;
    @(negedge clk);

    // Test 4: starvation limit lets fetch win the fifth arbitration
    a_d_req = 1; a_d_we = 0; a_d_addr = 32'h100; a_i_req = 1; a_i_addr = 32'h0C;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk("t4_owner", a_owner_d, (g < 4) ? 1 : 0);
      chk("t4_cs", a_cs, 1);
      chk("t4_starve", dut_a.u_pick.r_starve_cnt, (g < 4) ? g + 1 : 0);
      @(negedge clk);
      if (g < 4) begin
        chk("t4_dack", a_d_ack, 1);
        chk("t4_iack_off", a_i_ack, 0);
        chk("t4_drdata", a_d_rdata, 32'hDEADBEEF);
      end else begin
        chk("t4_iack", a_i_ack, 1);
        chk("t4_dack_off", a_d_ack, 0);
        chk("t4_irdata", a_i_rdata, img(3));
        a_d_req = 0; a_i_req = 0;
      end
      @(negedge clk);
      chk("t4_idle_cs", a_cs, 0);
    end
    chk("t4_starve_end", dut_a.u_pick.r_starve_cnt, 0);

    // Test 6: back-to-back fetches with two wait states
    b_i_req = 1; b_i_addr = 32'h0;
    for (int k = 0; k < 55; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (b_d_ack) chk("t6_dack_off", b_d_ack, 0);
      end while (!b_i_ack && n < 12);
      chk("t6_latency", n, (k == 0) ? 4 : 5);
      chk("t6_irdata", b_i_rdata, img(k));
      if (k < 54) b_i_addr = (k + 1) * 4;
      else b_i_req = 0;
    end
    @(negedge clk);

    // Test 5: reset during a wait-stated write, then a normal read
    b_d_req = 1; b_d_we = 1; b_d_addr = 32'h40; b_d_wdata = 32'h12345678;
    @(negedge clk);
    chk("t5_cs_access", b_cs, 1);
    chk("t5_we_access", b_we, 1);
    rst = 1;
    @(negedge clk);
    chk("t5_cs_rst", b_cs, 0);
    chk("t5_we_rst", b_we, 0);
    chk("t5_dack_rst", b_d_ack, 0);
    chk("t5_owner_rst", b_owner_d, 0);
    rst = 0; b_d_req = 0; b_d_we = 0; b_d_wdata = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_dack", b_d_ack, 0);
    end
    b_d_req = 1; b_d_addr = 32'h10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_d_ack && n < 12);
    chk("t5_latency", n, 4);
    chk("t5_drdata", b_d_rdata, img(4));
    chk("t5_iack_off", b_i_ack, 0);
    b_d_req = 0;
    @(negedge clk);
    chk("t5_idle_cs", b_cs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
